// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD command constants, FSM encoding and command helpers
package lcd_pkg;

  localparam logic [8:0] LCD_FUNC_8BIT = 9'h038;
  localparam logic [8:0] LCD_DISP_ON   = 9'h00E;
  localparam logic [8:0] LCD_CLEAR     = 9'h001;
  localparam logic [8:0] LCD_ENTRY_INC = 9'h006;
  localparam logic       LCD_CHAR_RS   = 1'b1;
  localparam logic [1:0] INIT_LAST     = 2'd3;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } lcd_state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } lcd_grant_e;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic [8:0] word);
    return (word[8] != LCD_CHAR_RS) && (word[7:0] != 8'h00) && (word[7:2] == 6'd0);
  endfunction

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    logic [8:0] w;
    case (idx)
      2'd0:    w = LCD_FUNC_8BIT;
      2'd1:    w = LCD_DISP_ON;
      2'd2:    w = LCD_CLEAR;
      default: w = LCD_ENTRY_INC;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// rtl/lcd_bus_arbiter_if.sv - requester handshakes and character-LCD pins for lcd_bus_arbiter
interface lcd_bus_arbiter_if;

  logic       req_a;
  logic [8:0] word_a;
  logic       ack_a;
  logic       req_b;
  logic [8:0] word_b;
  logic       ack_b;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       ready;
  logic       busy;

  modport master (
    input  req_a, word_a, req_b, word_b,
    output ack_a, ack_b, lcd_rs, lcd_rw, lcd_e, lcd_db, ready, busy
  );

  modport slave (
    output req_a, word_a, req_b, word_b,
    input  ack_a, ack_b, lcd_rs, lcd_rw, lcd_e, lcd_db, ready, busy
  );

endinterface

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter; done is high while the count is zero
module lcd_delay_timer #(
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - LCD init sequencer and two-port write arbiter; LCD_FIXED_PRIO_EN gives port A fixed priority
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 12,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_POWERUP = 750000,
  parameter int CNT_W     = 20
) (
  input logic               clk,
  input logic               reset,
  lcd_bus_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);

  lcd_state_e       state, state_n;
  lcd_grant_e       last_grant, last_grant_n;
  logic [1:0]       idx, idx_n;
  logic             ready_q, ready_n;
  logic [8:0]       word_q, word_n;
  logic             ack_a_q, ack_a_n;
  logic             ack_b_q, ack_b_n;
  logic             grant_a, grant_b;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  // The timer comes out of reset already loaded with the power-up wait.
  lcd_delay_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_POWERUP)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
`ifdef LCD_FIXED_PRIO_EN
    grant_a = bus.req_a;
    grant_b = bus.req_b && !bus.req_a;
`else
    if (bus.req_a && bus.req_b) begin
      grant_a = (last_grant == GRANT_B);
      grant_b = (last_grant == GRANT_A);
    end else begin
      grant_a = bus.req_a;
      grant_b = bus.req_b;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_POWERUP;
      last_grant <= GRANT_B;
      idx        <= 2'd0;
      ready_q    <= 1'b0;
      word_q     <= 9'd0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      idx        <= idx_n;
      ready_q    <= ready_n;
      word_q     <= word_n;
      ack_a_q    <= ack_a_n;
      ack_b_q    <= ack_b_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    idx_n        = idx;
    ready_n      = ready_q;
    word_n       = word_q;
    ack_a_n      = 1'b0;
    ack_b_n      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state)
      S_POWERUP: begin
        if (tmr_done) state_n = S_INIT;
      end
      S_INIT: begin
        word_n   = init_word(idx);
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
        state_n  = S_SETUP;
      end
      S_IDLE: begin
        if (grant_a || grant_b) begin
          word_n       = grant_a ? bus.word_a : bus.word_b;
          last_grant_n = grant_a ? GRANT_A : GRANT_B;
          ack_a_n      = grant_a;
          ack_b_n      = grant_b;
          tmr_load     = 1'b1;
          tmr_val      = LD_SETUP;
          state_n      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = LD_PULSE;
          state_n  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
          state_n  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(word_q) ? LD_CLEAR : LD_EXEC;
          state_n  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (tmr_done) begin
          if (!ready_q && (idx != INIT_LAST)) begin
            idx_n   = idx + 2'd1;
            state_n = S_INIT;
          end else begin
            ready_n = 1'b1;
            word_n  = 9'd0;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_POWERUP;
    endcase
  end

  assign bus.lcd_e  = (state == S_PULSE);
  assign bus.lcd_rs = word_q[8];
  assign bus.lcd_db = word_q[7:0];
  assign bus.lcd_rw = 1'b0;
  assign bus.ack_a  = ack_a_q;
  assign bus.ack_b  = ack_b_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - scoreboard bench for lcd_bus_arbiter with shortened bus timing
module tb_lcd_bus_arbiter;

  localparam int T_SETUP   = 1;
  localparam int T_PULSE   = 3;
  localparam int T_HOLD    = 1;
  localparam int T_EXEC    = 5;
  localparam int T_CLEAR   = 20;
  localparam int T_POWERUP = 10;
  localparam int CNT_W     = 20;

  // Rise-to-rise spacing of consecutive strobes when the next word is already waiting.
  localparam int GAP_FIRST = T_POWERUP + 1 + T_SETUP;
  localparam int GAP_EXEC  = T_PULSE + T_HOLD + T_EXEC + 1 + T_SETUP;
  localparam int GAP_CLEAR = T_PULSE + T_HOLD + T_CLEAR + 1 + T_SETUP;

  typedef struct {
    logic [8:0] word;
    int         gap;
    int         wt;
    bit         chk_idle;
  } pulse_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_arbiter_if bus_if ();

  lcd_bus_arbiter #(
    .T_SETUP   (T_SETUP),
    .T_PULSE   (T_PULSE),
    .T_HOLD    (T_HOLD),
    .T_EXEC    (T_EXEC),
    .T_CLEAR   (T_CLEAR),
    .T_POWERUP (T_POWERUP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int     n_pass  = 0;
  int     n_total = 0;
  int     cyc     = 0;
  pulse_t exp_pulse[$];
  bit     exp_ack[$];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_pulse(input logic [8:0] w, input int gap, input int wt, input bit ci);
    pulse_t p;
    p.word = w;
    p.gap = gap;
    p.wt = wt;
    p.chk_idle = ci;
    exp_pulse.push_back(p);
  endtask

  task automatic push_init();
    push_pulse(9'h038, GAP_FIRST, T_EXEC, 1'b0);
    push_pulse(9'h00E, GAP_EXEC, T_EXEC, 1'b0);
    push_pulse(9'h001, GAP_EXEC, T_CLEAR, 1'b0);
    push_pulse(9'h006, GAP_CLEAR, T_EXEC, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit side, input string name, output int k);
    k = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((side ? bus_if.ack_b : bus_if.ack_a) == 1'b1) begin
        k = cyc;
        break;
      end
    end
    if (k < 0) chk(1'b0, name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus_if.busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(1'b0, name, 1, 0);
  endtask

  task automatic serve(input bit side, input logic [8:0] w0, input logic [8:0] w1,
                       input logic [8:0] w2, input logic [8:0] w3);
    logic [8:0] ws [4];
    int k;
    ws = '{w0, w1, w2, w3};
    if (side) begin bus_if.word_b = ws[0]; bus_if.req_b = 1'b1; end
    else begin bus_if.word_a = ws[0]; bus_if.req_a = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      wait_ack(side, side ? "serve_ack_b" : "serve_ack_a", k);
      if (i < 3) begin
        if (side) bus_if.word_b = ws[i+1];
        else bus_if.word_a = ws[i+1];
      end else begin
        if (side) bus_if.req_b = 1'b0;
        else bus_if.req_a = 1'b0;
      end
    end
  endtask

  // Monitor: checks every strobe and every ack against the expectation queues.
  initial begin
    pulse_t     cur;
    bit         have_cur = 1'b0;
    bit         in_reset = 1'b0;
    bit         e_prev = 1'b0;
    bit         ack_prev = 1'b0;
    bit         rdy_prev = 1'b0;
    bit         s;
    int         e_len = 0;
    int         last_rise = 0;
    int         idle_due = -1;
    logic [8:0] rsdb;
    logic [8:0] prev_rsdb = 9'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        in_reset = 1'b1;
        have_cur = 1'b0;
        e_prev = 1'b0;
        ack_prev = 1'b0;
        rdy_prev = 1'b0;
        e_len = 0;
        idle_due = -1;
      end else begin
        if (in_reset) begin
          last_rise = cyc;
          in_reset = 1'b0;
        end
        rsdb = {bus_if.lcd_rs, bus_if.lcd_db};
        if (bus_if.lcd_e && !e_prev) begin
          if (exp_pulse.size() == 0) begin
            chk(1'b0, "unexpected_pulse", int'(rsdb), 0);
          end else begin
            cur = exp_pulse[0];
            have_cur = 1'b1;
            if (cur.gap != 0) chk(cyc - last_rise == cur.gap, "rise_gap", cyc - last_rise, cur.gap);
            chk(prev_rsdb == cur.word, "setup_data", int'(prev_rsdb), int'(cur.word));
            chk(rsdb == cur.word, "pulse_data", int'(rsdb), int'(cur.word));
            chk(bus_if.lcd_rw == 1'b0, "lcd_rw", int'(bus_if.lcd_rw), 0);
          end
          last_rise = cyc;
          e_len = 0;
        end
        if (bus_if.lcd_e) e_len++;
        if (!bus_if.lcd_e && e_prev && have_cur) begin
          chk(e_len == T_PULSE, "e_width", e_len, T_PULSE);
          chk(rsdb == cur.word, "hold_data", int'(rsdb), int'(cur.word));
          if (cur.chk_idle) idle_due = cyc + T_HOLD + cur.wt;
          void'(exp_pulse.pop_front());
          have_cur = 1'b0;
        end
        if (idle_due >= 0 && cyc == idle_due - 1)
          chk(bus_if.busy == 1'b1, "busy_exec", int'(bus_if.busy), 1);
        if (idle_due >= 0 && cyc == idle_due) begin
          chk(bus_if.busy == 1'b0, "busy_idle", int'(bus_if.busy), 0);
          chk(rsdb == 9'd0, "idle_bus", int'(rsdb), 0);
          idle_due = -1;
        end
        if (bus_if.ready && !rdy_prev)
          chk(cyc - last_rise == T_PULSE + T_HOLD + T_EXEC, "ready_rise",
              cyc - last_rise, T_PULSE + T_HOLD + T_EXEC);
        if (bus_if.ack_a || bus_if.ack_b) begin
          chk(!(bus_if.ack_a && bus_if.ack_b), "ack_both", 1, 0);
          chk(!ack_prev, "ack_width", int'(ack_prev), 0);
          chk(bus_if.ready == 1'b1, "ack_before_ready", int'(bus_if.ready), 1);
          if (exp_ack.size() == 0) begin
            chk(1'b0, "unexpected_ack", int'(bus_if.ack_b), 0);
          end else begin
            s = exp_ack.pop_front();
            chk(bus_if.ack_b == s, "ack_side", int'(bus_if.ack_b), int'(s));
          end
        end
        ack_prev = bus_if.ack_a || bus_if.ack_b;
        e_prev = bus_if.lcd_e;
        prev_rsdb = rsdb;
        rdy_prev = bus_if.ready;
      end
    end
  end

  initial begin
    int  k0, ka, kb, kr;
    bit  seen;
    bus_if.req_a = 1'b0;
    bus_if.word_a = 9'd0;
    bus_if.req_b = 1'b0;
    bus_if.word_b = 9'd0;
    repeat (3) tick();
    chk(bus_if.lcd_e == 1'b0, "rst_lcd_e", int'(bus_if.lcd_e), 0);
    chk({bus_if.lcd_rs, bus_if.lcd_db} == 9'd0, "rst_rs_db", int'({bus_if.lcd_rs, bus_if.lcd_db}), 0);
    chk(bus_if.lcd_rw == 1'b0, "rst_lcd_rw", int'(bus_if.lcd_rw), 0);
    chk({bus_if.ack_a, bus_if.ack_b} == 2'b00, "rst_acks", int'({bus_if.ack_a, bus_if.ack_b}), 0);
    chk(bus_if.ready == 1'b0, "rst_ready", int'(bus_if.ready), 0);
    chk(bus_if.busy == 1'b1, "rst_busy", int'(bus_if.busy), 1);

    push_init();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus_if.ready) begin seen = 1'b1; break; end
    end
    chk(seen, "init_ready", int'(seen), 1);

    // Single character from A: ack one cycle after the request.
    exp_ack.push_back(1'b0);
    push_pulse(9'h141, 0, T_EXEC, 1'b1);
    bus_if.word_a = 9'h141;
    bus_if.req_a = 1'b1;
    k0 = cyc;
    wait_ack(1'b0, "ack_a_single", ka);
    bus_if.req_a = 1'b0;
    bus_if.word_a = 9'h1FF;
    chk(ka - k0 == 1, "ack_latency", ka - k0, 1);
    wait_idle("idle_single");

    // Clear from B holds the bus for the long wait; a dropped B request is never served.
    exp_ack.push_back(1'b1);
    push_pulse(9'h001, 0, T_CLEAR, 1'b0);
    exp_ack.push_back(1'b0);
    push_pulse(9'h142, GAP_CLEAR, T_EXEC, 1'b1);
    bus_if.word_b = 9'h001;
    bus_if.req_b = 1'b1;
    wait_ack(1'b1, "ack_b_clear", kb);
    bus_if.req_b = 1'b0;
    bus_if.word_a = 9'h142;
    bus_if.req_a = 1'b1;
    repeat (3) tick();
    bus_if.word_b = 9'h0FF;
    bus_if.req_b = 1'b1;
    repeat (3) tick();
    bus_if.req_b = 1'b0;
    wait_ack(1'b0, "ack_a_after_clear", ka);
    bus_if.req_a = 1'b0;
    chk(ka - kb == T_SETUP + T_PULSE + T_HOLD + T_CLEAR + 1, "clear_occupancy",
        ka - kb, T_SETUP + T_PULSE + T_HOLD + T_CLEAR + 1);
    wait_idle("idle_clear");

    // Both ports stream four words each; last grant was A.
    for (int i = 0; i < 8; i++) begin
      bit         side;
      logic [8:0] w;
`ifdef LCD_FIXED_PRIO_EN
      side = (i >= 4);
      w = side ? 9'(9'h161 + (i - 4)) : 9'(9'h130 + i);
`else
      side = (i % 2 == 0);
      w = side ? 9'(9'h161 + i / 2) : 9'(9'h130 + i / 2);
`endif
      exp_ack.push_back(side);
      push_pulse(w, (i == 0) ? 0 : GAP_EXEC, T_EXEC, i == 7);
    end
    fork
      serve(1'b0, 9'h130, 9'h131, 9'h132, 9'h133);
      serve(1'b1, 9'h161, 9'h162, 9'h163, 9'h164);
    join
    wait_idle("idle_stream");

    // Reset while E is high aborts the word and restarts the whole init.
    exp_ack.push_back(1'b0);
    push_pulse(9'h148, 0, T_EXEC, 1'b0);
    bus_if.word_a = 9'h148;
    bus_if.req_a = 1'b1;
    wait_ack(1'b0, "ack_a_pre_reset", ka);
    bus_if.req_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.lcd_e) begin seen = 1'b1; break; end
      tick();
    end
    chk(seen, "e_high_before_reset", int'(seen), 1);
    #2 reset = 1'b0;
    #1;
    chk(bus_if.lcd_e == 1'b0, "mid_rst_lcd_e", int'(bus_if.lcd_e), 0);
    chk({bus_if.ack_a, bus_if.ack_b} == 2'b00, "mid_rst_acks", int'({bus_if.ack_a, bus_if.ack_b}), 0);
    chk(bus_if.ready == 1'b0, "mid_rst_ready", int'(bus_if.ready), 0);
    chk(bus_if.busy == 1'b1, "mid_rst_busy", int'(bus_if.busy), 1);
    chk(bus_if.lcd_db == 8'd0, "mid_rst_db", int'(bus_if.lcd_db), 0);
    exp_pulse.delete();
    exp_ack.delete();
    repeat (3) tick();

    // A request held through power-up is served right after ready.
    push_init();
    exp_ack.push_back(1'b0);
    push_pulse(9'h14B, GAP_EXEC, T_EXEC, 1'b1);
    bus_if.word_a = 9'h14B;
    bus_if.req_a = 1'b1;
    reset = 1'b1;
    kr = -1;
    ka = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus_if.ready && kr < 0) kr = cyc;
      if (bus_if.ack_a) begin ka = cyc; break; end
    end
    bus_if.req_a = 1'b0;
    chk(ka >= 0 && kr >= 0 && ka - kr == 1, "ack_after_ready", ka - kr, 1);
    wait_idle("idle_final");
    repeat (3) tick();

    chk(exp_pulse.size() == 0, "pulses_left", exp_pulse.size(), 0);
    chk(exp_ack.size() == 0, "acks_left", exp_ack.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
